// File: rtl/color_manager_config_applier_if.sv
// Config-bus link between the config manager (master) and the settings applier (slave).
// A write transfers when C_Valid and C_Rdy are both high on a clock edge.
interface color_manager_config_applier_if #(
    parameter int C_ADDR_WIDTH = 3,
    parameter int C_DATA_WIDTH = 14
);
    logic [C_ADDR_WIDTH-1:0] C_Addr;
    logic [C_DATA_WIDTH-1:0] C_Data;
    logic                    C_Valid;
    logic                    C_Rdy;

    modport master (output C_Addr, output C_Data, output C_Valid, input C_Rdy);
    modport slave  (input C_Addr, input C_Data, input C_Valid, output C_Rdy);
endinterface

// File: rtl/color_manager_config_applier.sv
// Applies config-bus writes to the live UART and VGA settings. UART fields wait for an idle
// UART, resolution waits for a frame start; both waits give up after TIMEOUT_CYCLES.
module color_manager_config_applier #(
    parameter int C_ADDR_WIDTH   = 3,
    parameter int C_DATA_WIDTH   = 14,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int TIMEOUT_WIDTH  = 20
) (
    input  logic        Clk,
    input  logic        Rst,
    color_manager_config_applier_if.slave cfg,
    input  logic        Uart_Busy,
    input  logic        Frame_Start,
    output logic [2:0]  Baud_Sel,
    output logic [1:0]  Parity_Sel,
    output logic        Stop_Sel,
    output logic [1:0]  Res_Sel,
    output logic [1:0]  Quadrant_Sel,
    output logic [13:0] Color,
    output logic        Update_Done,
    output logic        Update_Timeout,
    output logic        Addr_Error
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_DISPATCH  = 2'd1,
        S_WAIT_UART = 2'd2,
        S_WAIT_VGA  = 2'd3
    } state_t;

    localparam logic [C_ADDR_WIDTH-1:0]  ADDR_BAUD   = C_ADDR_WIDTH'(0);
    localparam logic [C_ADDR_WIDTH-1:0]  ADDR_PARITY = C_ADDR_WIDTH'(1);
    localparam logic [C_ADDR_WIDTH-1:0]  ADDR_STOP   = C_ADDR_WIDTH'(2);
    localparam logic [C_ADDR_WIDTH-1:0]  ADDR_RES    = C_ADDR_WIDTH'(3);
    localparam logic [C_ADDR_WIDTH-1:0]  ADDR_QUAD   = C_ADDR_WIDTH'(4);
    localparam logic [C_ADDR_WIDTH-1:0]  ADDR_COLOR  = C_ADDR_WIDTH'(5);
    localparam logic [TIMEOUT_WIDTH-1:0] CNT_LAST    = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [C_ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
    logic [C_DATA_WIDTH-1:0] pend_data_q, pend_data_d;
    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
    logic                    rdy_q;
    logic [2:0]              baud_q, baud_d;
    logic [1:0]              parity_q, parity_d;
    logic                    stop_q, stop_d;
    logic [1:0]              res_q, res_d;
    logic [1:0]              quad_q, quad_d;
    logic [13:0]             color_q, color_d;
    logic                    done_q, timeout_q, addr_err_q;
    logic                    commit_s, timeout_s, addr_err_s;

    // State register plus every registered output and the pending write.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= S_IDLE;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            cnt_q       <= '0;
            rdy_q       <= 1'b1;
            baud_q      <= 3'd2;
            parity_q    <= 2'd0;
            stop_q      <= 1'b0;
            res_q       <= 2'd0;
            quad_q      <= 2'd0;
            color_q     <= 14'd0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            cnt_q       <= cnt_d;
            rdy_q       <= (state_d == S_IDLE);
            baud_q      <= baud_d;
            parity_q    <= parity_d;
            stop_q      <= stop_d;
            res_q       <= res_d;
            quad_q      <= quad_d;
            color_q     <= color_d;
            done_q      <= commit_s;
            timeout_q   <= timeout_s;
            addr_err_q  <= addr_err_s;
        end
    end

    // Next-state logic; a commit condition wins over timeout expiry.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cfg.C_Valid) state_d = S_DISPATCH;
                else             state_d = S_IDLE;
            end
            S_DISPATCH: begin
                case (pend_addr_q)
                    ADDR_BAUD, ADDR_PARITY, ADDR_STOP: state_d = S_WAIT_UART;
                    ADDR_RES:                          state_d = S_WAIT_VGA;
                    default:                           state_d = S_IDLE;
                endcase
            end
            S_WAIT_UART: begin
                if (!Uart_Busy || (cnt_q == CNT_LAST)) state_d = S_IDLE;
                else                                   state_d = S_WAIT_UART;
            end
            S_WAIT_VGA: begin
                if (Frame_Start || (cnt_q == CNT_LAST)) state_d = S_IDLE;
                else                                    state_d = S_WAIT_VGA;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Per-state actions: latch the request, run the wait counter, raise commit/drop/error.
    always_comb begin
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        cnt_d       = cnt_q;
        commit_s    = 1'b0;
        timeout_s   = 1'b0;
        addr_err_s  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cfg.C_Valid) begin
                    pend_addr_d = cfg.C_Addr;
                    pend_data_d = cfg.C_Data;
                end else begin
                    pend_addr_d = pend_addr_q;
                end
            end
            S_DISPATCH: begin
                case (pend_addr_q)
                    ADDR_QUAD, ADDR_COLOR:                       commit_s   = 1'b1;
                    ADDR_BAUD, ADDR_PARITY, ADDR_STOP, ADDR_RES: cnt_d      = '0;
                    default:                                     addr_err_s = 1'b1;
                endcase
            end
            S_WAIT_UART: begin
                if (!Uart_Busy)             commit_s  = 1'b1;
                else if (cnt_q == CNT_LAST) timeout_s = 1'b1;
                else                        cnt_d     = cnt_q + TIMEOUT_WIDTH'(1);
            end
            S_WAIT_VGA: begin
                if (Frame_Start)            commit_s  = 1'b1;
                else if (cnt_q == CNT_LAST) timeout_s = 1'b1;
                else                        cnt_d     = cnt_q + TIMEOUT_WIDTH'(1);
            end
            default: cnt_d = '0;
        endcase
    end

    // Field update on commit; narrow fields take the low bits of the pending data.
    always_comb begin
        baud_d   = baud_q;
        parity_d = parity_q;
        stop_d   = stop_q;
        res_d    = res_q;
        quad_d   = quad_q;
        color_d  = color_q;
        if (commit_s) begin
            case (pend_addr_q)
                ADDR_BAUD:   baud_d   = pend_data_q[2:0];
                ADDR_PARITY: parity_d = pend_data_q[1:0];
                ADDR_STOP:   stop_d   = pend_data_q[0];
                ADDR_RES:    res_d    = pend_data_q[1:0];
                ADDR_QUAD:   quad_d   = pend_data_q[1:0];
                ADDR_COLOR:  color_d  = pend_data_q[13:0];
                default:     color_d  = color_q;
            endcase
        end else begin
            color_d = color_q;
        end
    end

    assign cfg.C_Rdy      = rdy_q;
    assign Baud_Sel       = baud_q;
    assign Parity_Sel     = parity_q;
    assign Stop_Sel       = stop_q;
    assign Res_Sel        = res_q;
    assign Quadrant_Sel   = quad_q;
    assign Color          = color_q;
    assign Update_Done    = done_q;
    assign Update_Timeout = timeout_q;
    assign Addr_Error     = addr_err_q;
endmodule

// File: tb/tb_color_manager_config_applier.sv
// Random config writes against a settings model; a monitor matches every result pulse
// (kind, cycle, live settings) to the scoreboard entry queued when the write was issued.
module tb_color_manager_config_applier;
    localparam int TMO = 16;
    localparam int K_DONE = 1, K_TMO = 2, K_ERR = 3;

    typedef struct {
        int          kind;
        int          cyc;
        logic [23:0] fields;
    } exp_t;

    logic Clk = 1'b0, Rst = 1'b1, Uart_Busy = 1'b1, Frame_Start = 1'b0;
    logic [2:0] Baud_Sel;
    logic [1:0] Parity_Sel, Res_Sel, Quadrant_Sel;
    logic Stop_Sel, Update_Done, Update_Timeout, Addr_Error;
    logic [13:0] Color;

    color_manager_config_applier_if #(.C_ADDR_WIDTH(3), .C_DATA_WIDTH(14)) cfg_if ();

    color_manager_config_applier #(
        .C_ADDR_WIDTH(3), .C_DATA_WIDTH(14), .TIMEOUT_CYCLES(TMO), .TIMEOUT_WIDTH(4)
    ) dut (
        .Clk(Clk), .Rst(Rst), .cfg(cfg_if), .Uart_Busy(Uart_Busy), .Frame_Start(Frame_Start),
        .Baud_Sel(Baud_Sel), .Parity_Sel(Parity_Sel), .Stop_Sel(Stop_Sel), .Res_Sel(Res_Sel),
        .Quadrant_Sel(Quadrant_Sel), .Color(Color), .Update_Done(Update_Done),
        .Update_Timeout(Update_Timeout), .Addr_Error(Addr_Error)
    );

    always #5 Clk = ~Clk;

    int checks = 0, errors = 0, cyc = 0;
    exp_t sb[$];
    // Live settings model: {baud, parity, stop, res, quadrant, color}.
    logic [2:0] m_baud = 3'd2;
    logic [1:0] m_par = 2'd0, m_res = 2'd0, m_quad = 2'd0;
    logic m_stop = 1'b0;
    logic [13:0] m_color = 14'd0;

    always @(posedge Clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [23:0] model_fields();
        return {m_baud, m_par, m_stop, m_res, m_quad, m_color};
    endfunction

    task automatic model_reset();
        m_baud = 3'd2; m_par = 2'd0; m_stop = 1'b0; m_res = 2'd0; m_quad = 2'd0; m_color = 14'd0;
    endtask

    // Issue one write from an idle negedge; k = wait cycle on which the commit condition
    // appears (0 = never). Returns at the negedge after the write has resolved.
    task automatic do_write(input logic [2:0] a, input logic [13:0] d, input int k);
        int a_cyc, n;
        exp_t e;
        bit uart, vga;
        uart = (a <= 3'd2);
        vga  = (a == 3'd3);
        cfg_if.C_Valid = 1'b1;
        cfg_if.C_Addr  = a;
        cfg_if.C_Data  = d;
        @(negedge Clk);
        a_cyc = cyc;
        check("rdy_low_after_accept", {31'd0, cfg_if.C_Rdy}, 32'd0);
        n = 0;
        if (uart || vga) begin
            if (k >= 1 && k <= TMO) begin
                n = k;
                e.kind = K_DONE;
            end else begin
                n = TMO;
                e.kind = K_TMO;
            end
        end else if (a >= 3'd6) begin
            e.kind = K_ERR;
        end else begin
            e.kind = K_DONE;
        end
        if (e.kind == K_DONE) begin
            case (a)
                3'd0: m_baud = d[2:0];
                3'd1: m_par = d[1:0];
                3'd2: m_stop = d[0];
                3'd3: m_res = d[1:0];
                3'd4: m_quad = d[1:0];
                default: m_color = d;
            endcase
        end
        e.cyc = a_cyc + 1 + n;
        e.fields = model_fields();
        sb.push_back(e);
        for (int j = 0; j <= n; j++) begin
            // Requests while busy must be ignored.
            cfg_if.C_Valid = 1'($urandom);
            cfg_if.C_Addr  = 3'($urandom);
            cfg_if.C_Data  = 14'($urandom);
            Uart_Busy   = uart ? !(j == k) : 1'($urandom);
            Frame_Start = vga ? (j == k) : 1'($urandom);
            if (j < n) @(negedge Clk);
        end
        @(negedge Clk);
        cfg_if.C_Valid = 1'b0;
        Uart_Busy   = 1'($urandom);
        Frame_Start = 1'($urandom);
    endtask

    // Monitor: every result pulse must match the oldest scoreboard entry.
    always @(negedge Clk) begin
        exp_t e;
        int np;
        if (!Rst) begin
            np = int'(Update_Done) + int'(Update_Timeout) + int'(Addr_Error);
            if (np > 1) check("pulses_exclusive", np, 1);
            if (np != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_pulse", {29'd0, Update_Done, Update_Timeout, Addr_Error}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("result_kind", Update_Done ? K_DONE : (Update_Timeout ? K_TMO : K_ERR), e.kind);
                    check("result_cycle", cyc, e.cyc);
                    check("live_fields", {8'd0, Baud_Sel, Parity_Sel, Stop_Sel, Res_Sel, Quadrant_Sel, Color},
                          {8'd0, e.fields});
                    check("rdy_after_result", {31'd0, cfg_if.C_Rdy}, 32'd1);
                end
            end
        end
    end

    initial begin
        cfg_if.C_Valid = 1'b0;
        cfg_if.C_Addr  = 3'd0;
        cfg_if.C_Data  = 14'd0;
        repeat (3) @(negedge Clk);
        check("reset_fields", {8'd0, Baud_Sel, Parity_Sel, Stop_Sel, Res_Sel, Quadrant_Sel, Color},
              {8'd0, model_fields()});
        check("reset_rdy", {31'd0, cfg_if.C_Rdy}, 32'd1);
        check("reset_pulses", {29'd0, Update_Done, Update_Timeout, Addr_Error}, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        do_write(3'd5, 14'h1ABC, 0);
        check("color_1abc", {18'd0, Color}, 32'h1ABC);
        do_write(3'd0, 14'd4, 6);
        check("baud_after_idle", {29'd0, Baud_Sel}, 32'd4);
        do_write(3'd3, 14'd2, 0);
        check("res_after_timeout", {30'd0, Res_Sel}, 32'd0);
        do_write(3'd3, 14'd2, TMO);
        check("res_frame_at_last", {30'd0, Res_Sel}, 32'd2);
        do_write(3'd7, 14'h3FFF, 0);
        do_write(3'd6, 14'h0155, 0);

        for (int i = 0; i < 200; i++) begin
            do_write(3'($urandom), 14'($urandom), int'($urandom_range(0, TMO + 3)));
        end

        // Reset mid-wait drops the pending parity write.
        Uart_Busy      = 1'b1;
        cfg_if.C_Valid = 1'b1;
        cfg_if.C_Addr  = 3'd1;
        cfg_if.C_Data  = 14'd1;
        @(negedge Clk);
        cfg_if.C_Valid = 1'b0;
        repeat (5) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        model_reset();
        check("rst_fields", {8'd0, Baud_Sel, Parity_Sel, Stop_Sel, Res_Sel, Quadrant_Sel, Color},
              {8'd0, model_fields()});
        check("rst_rdy", {31'd0, cfg_if.C_Rdy}, 32'd1);
        Uart_Busy = 1'b0;
        repeat (20) @(negedge Clk);
        check("rst_parity", {30'd0, Parity_Sel}, 32'd0);
        do_write(3'd1, 14'd3, 1);
        check("parity_after_rst", {30'd0, Parity_Sel}, 32'd3);

        repeat (3) @(negedge Clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
